// File: rtl/dmx8_4bits_scatter_if.sv
// dmx8_4bits_scatter_if: control, stream and register-bank signals of the 4-bit scatter demux
interface dmx8_4bits_scatter_if #(parameter int WIDTH = 4);
    logic clr, wr, start, in_valid, in_ready, s2, s1, s0, busy, done;
    logic [WIDTH-1:0] d, a, b, c, d_o, e, f, g, h;
    logic [7:0] vld;
    modport master (
        output clr, d, s2, s1, s0, wr, start, in_valid,
        input in_ready, a, b, c, d_o, e, f, g, h, vld, busy, done
    );
    modport slave (
        input clr, d, s2, s1, s0, wr, start, in_valid,
        output in_ready, a, b, c, d_o, e, f, g, h, vld, busy, done
    );
endinterface

// File: rtl/dmx8_4bits_scatter.sv
// dmx8_4bits_scatter: registered 1-to-8 word demux with direct writes and an in-order stream fill
module dmx8_4bits_scatter #(
    parameter int WIDTH = 4,
    parameter int LAST = 7
) (
    input logic clk,
    input logic reset,
    dmx8_4bits_scatter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    localparam logic [2:0] LAST_P = 3'(LAST);
    state_t state;
    logic [WIDTH-1:0] regs [8];
    logic [7:0] vld;
    logic [2:0] ptr;
    logic in_ready, busy, done;
    logic [2:0] sel;
    assign sel = {bus.s2, bus.s1, bus.s0};
    // in_ready/busy/done are kept as registers mirroring the state so outputs never see decode glitches
    always_ff @(posedge clk) begin
        if (reset || bus.clr) begin
            regs <= '{default: '0};
            vld <= '0;
            ptr <= '0;
            state <= IDLE;
            in_ready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        vld <= '0;
                        ptr <= '0;
                        state <= FILL;
                        in_ready <= 1'b1;
                        busy <= 1'b1;
                    end else if (bus.wr) begin
                        regs[sel] <= bus.d;
                        vld[sel] <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.in_valid && in_ready) begin
                        regs[ptr] <= bus.d;
                        vld[ptr] <= 1'b1;
                        if (ptr == LAST_P) begin
                            state <= DONE;
                            in_ready <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            ptr <= ptr + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr <= '0;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.a = regs[0];
    assign bus.b = regs[1];
    assign bus.c = regs[2];
    assign bus.d_o = regs[3];
    assign bus.e = regs[4];
    assign bus.f = regs[5];
    assign bus.g = regs[6];
    assign bus.h = regs[7];
    assign bus.vld = vld;
    assign bus.in_ready = in_ready;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: doc/dmx8_4bits_scatter.md
Name: dmx8_4bits_scatter

Overview:
- Registered 1-to-8 demultiplexer for 4-bit words. It is the write-side counterpart to the 8-to-1 word selector in the alu4 datapath.
- Holds eight 4-bit output registers a..h.
- Two ways to load them:
  - Direct write: one word, addressed by s2/s1/s0.
  - Stream fill: a valid/ready handshake scatters consecutive words into a, b, c, ... in order, then pulses done.
- Feeds operand banks that the selector reads back.

Parameters:
- WIDTH, 4, bits per word; all data ports and output registers are WIDTH wide.
- LAST, 7, index of the final register written in a stream fill (legal 0..7); the fill covers registers 0..LAST.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of data and flags; aborts any fill.
- d  input  WIDTH  write data, used in both modes.
- s2  input  1  direct-write select, MSB.
- s1  input  1  direct-write select.
- s0  input  1  direct-write select, LSB.
- wr  input  1  direct-write strobe; honoured in IDLE only.
- start  input  1  begins a stream fill; honoured in IDLE only.
- in_valid  input  1  stream data valid.
- in_ready  output  1  stream ready; high only in FILL.
- a, b, c, d_o, e, f, g, h  output  WIDTH each  registers 0..7 (d_o avoids a clash with input d).
- vld  output  8  per-register written flag; bit i corresponds to register i.
- busy  output  1  high while in FILL or DONE.
- done  output  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset: a..h = 0, vld = 0, ptr = 0, state = IDLE, in_ready = 0, busy = 0, done = 0.
- All outputs are registered. A write accepted at edge N is visible after edge N.
- Priority at each edge:
  1. reset
  2. clr
  3. start
  4. wr (IDLE) or the stream handshake (FILL)
- State IDLE:
  - start=1: vld <= 0, ptr <= 0, go to FILL. A wr in the same cycle is dropped.
  - else wr=1: register[{s2,s1,s0}] <= d, and vld bit {s2,s1,s0} <= 1. Other registers hold. No done pulse.
  - in_valid is ignored.
- State FILL:
  - in_ready = 1.
  - Handshake = in_valid & in_ready. On a handshake: register[ptr] <= d, vld[ptr] <= 1.
  - If ptr == LAST on that handshake: go to DONE. Otherwise ptr <= ptr+1.
  - No handshake: everything holds. Gaps of any length are legal.
  - wr, start and s2..s0 are ignored.
- State DONE:
  - Lasts one cycle. done = 1, in_ready = 0.
  - Next state IDLE, ptr <= 0.
  - wr and start are ignored in this cycle.
- done is a decoded Moore output: high exactly in DONE, i.e. the cycle after the final handshake.
- busy = (state != IDLE).
- clr in any state:
  - a..h <= 0, vld <= 0, ptr <= 0, state <= IDLE.
  - done is not generated.
  - Any handshake, wr or start in the same cycle is discarded.
- Reset mid-fill: identical to the reset values above. A partial fill is lost.
- ptr is 3 bits and never wraps within a fill; termination is by the LAST compare.
- Registers above LAST are untouched by a fill. They keep prior contents but their vld bits are cleared at start.
- With LAST = 0, the fill is a single handshake into register a, followed by DONE.
- No X propagation: outputs are driven only from registers.

Test Plan:
- Reset, then idle 5 cycles: a..h = 0, vld = 8'h00, in_ready = 0, busy = 0, done never asserted.
- Direct write: IDLE, {s2,s1,s0} = 3'b101, d = 4'hA, wr = 1 for one cycle. Next cycle f = 4'hA, vld = 8'b0010_0000, all other registers 0. Then write 3'b101 = 4'h3: f = 4'h3.
- Stream fill, LAST = 7: start, then send d = 1..8 with in_valid toggled 1,0,1,1,0,... Result a..h = 1..8, vld = 8'hFF. done high exactly one cycle, the cycle after the 8th handshake. in_ready drops with done. busy is high from the cycle after start through the done cycle.
- start and wr asserted together in IDLE with s = 3'b010, d = 4'hF: c is unchanged, state is FILL, vld = 0. A wr during FILL with s = 3'b000 does not modify a.
- clr mid-fill after 3 handshakes (a..c = 9,9,9): next cycle a..h = 0, vld = 0, in_ready = 0, busy = 0, no done pulse. A new start then fills from register a.
- LAST = 3 instance, and reset mid-fill:
  - After prior direct writes e = 4'h5, h = 4'h7, a fill of 4 words touches only a..d. Result vld = 8'h0F, e = 4'h5 and h = 4'h7 retained, done after the 4th handshake.
  - reset asserted after 2 handshakes returns all outputs to 0.
